// File: rtl/title_banner_ctrl.sv
// Title-banner sequencer: maps VGA counters onto a scaled, centred 142x16 ROM window
// and runs the TITLE / BLINK / GAME mode machine that gates the banner and starts play.
module title_banner_ctrl #(
  parameter int BANNER_X0    = 178,
  parameter int BANNER_Y0    = 200,
  parameter int SCALE_SHIFT  = 1,
  parameter int BLINK_FRAMES = 48,
  parameter int BLINK_HALF   = 8
) (
  input  logic       clock_25,
  input  logic       reset,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic       video_on,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       game_over,
  output logic [7:0] rom_x,
  output logic [3:0] rom_y,
  input  logic       rom_data,
  output logic       banner_pixel,
  output logic       banner_active,
  output logic       mode_title,
  output logic       game_start
);

  localparam int ROM_W  = 142;
  localparam int ROM_H  = 16;
  localparam int FCNT_W = $clog2(BLINK_FRAMES);

  localparam logic [9:0] X_LO = 10'(BANNER_X0);
  localparam logic [9:0] X_HI = 10'(BANNER_X0 + (ROM_W << SCALE_SHIFT));
  localparam logic [9:0] Y_LO = 10'(BANNER_Y0);
  localparam logic [9:0] Y_HI = 10'(BANNER_Y0 + (ROM_H << SCALE_SHIFT));

  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);
  localparam logic [FCNT_W-1:0] HALF      = FCNT_W'(BLINK_HALF);
  localparam logic [FCNT_W-1:0] HALF_LAST = FCNT_W'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    ST_TITLE,
    ST_BLINK,
    ST_GAME
  } state_t;

  state_t            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              blink_on_q, blink_on_d;
  logic              btn_prev_q, btn_prev_d;
  logic [7:0]        x1_q, x1_d;
  logic [3:0]        rom_y_q, rom_y_d;
  logic              win1_q, win1_d;
  logic [7:0]        rom_x_q, rom_x_d;
  logic              win2_q, win2_d;
  logic              banner_active_q, banner_active_d;
  logic              banner_pixel_q, banner_pixel_d;
  logic              mode_title_q, mode_title_d;
  logic              game_start_q, game_start_d;

  logic       in_win;
  logic       show;
  logic [9:0] h_off;
  logic [9:0] v_off;

  // Address pipeline: outside the window both addresses are forced to 0 so the ROM
  // is never addressed beyond its 142x16 extent.
  always_comb begin
    in_win = video_on && (h_count >= X_LO) && (h_count < X_HI)
                      && (v_count >= Y_LO) && (v_count < Y_HI);
    h_off  = h_count - X_LO;
    v_off  = v_count - Y_LO;

    rom_y_d = in_win ? 4'(v_off >> SCALE_SHIFT) : 4'd0;
    x1_d    = in_win ? 8'(h_off >> SCALE_SHIFT) : 8'd0;
    win1_d  = in_win;

    rom_x_d = x1_q;
    win2_d  = win1_q;

    show            = (state_q == ST_TITLE) || ((state_q == ST_BLINK) && blink_on_q);
    banner_active_d = win2_q && show;
    banner_pixel_d  = win2_q && show && rom_data;
  end

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    blink_on_d = blink_on_q;
    btn_prev_d = start_btn;

    case (state_q)
      ST_TITLE: begin
        if (start_btn && !btn_prev_q) begin
          state_d    = ST_BLINK;
          fcnt_d     = '0;
          blink_on_d = 1'b1;
        end
      end
      ST_BLINK: begin
        if (frame_tick) begin
          if (fcnt_q == FCNT_LAST) begin
            state_d = ST_GAME;
          end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
            if ((fcnt_q % HALF) == HALF_LAST) begin
              blink_on_d = !blink_on_q;
            end
          end
        end
      end
      ST_GAME: begin
        if (game_over) begin
          state_d = ST_TITLE;
        end
      end
      default: state_d = ST_TITLE;
    endcase

    mode_title_d = (state_d != ST_GAME);
    game_start_d = (state_d == ST_GAME) && (state_q != ST_GAME);
  end

  // btn_prev resets high so a button held through reset never counts as a press.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      state_q         <= ST_TITLE;
      fcnt_q          <= '0;
      blink_on_q      <= 1'b0;
      btn_prev_q      <= 1'b1;
      x1_q            <= '0;
      rom_y_q         <= '0;
      win1_q          <= 1'b0;
      rom_x_q         <= '0;
      win2_q          <= 1'b0;
      banner_active_q <= 1'b0;
      banner_pixel_q  <= 1'b0;
      mode_title_q    <= 1'b1;
      game_start_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      fcnt_q          <= fcnt_d;
      blink_on_q      <= blink_on_d;
      btn_prev_q      <= btn_prev_d;
      x1_q            <= x1_d;
      rom_y_q         <= rom_y_d;
      win1_q          <= win1_d;
      rom_x_q         <= rom_x_d;
      win2_q          <= win2_d;
      banner_active_q <= banner_active_d;
      banner_pixel_q  <= banner_pixel_d;
      mode_title_q    <= mode_title_d;
      game_start_q    <= game_start_d;
    end
  end

  assign rom_x         = rom_x_q;
  assign rom_y         = rom_y_q;
  assign banner_active = banner_active_q;
  assign banner_pixel  = banner_pixel_q;
  assign mode_title    = mode_title_q;
  assign game_start    = game_start_q;

endmodule
